water_reminder_timer: RTL and testbench

//  Parametrised hydration-reminder countdown timer; successor to the fixed timer block.

---
 rtl/water_reminder_timer.sv | 214 +++++++++++++++++++++
 tb/tb_water_reminder_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/water_reminder_timer.sv
// Hydration reminder: counts down a selectable interval held as BCD HHMMSS,
// raises remind at zero, and supports acknowledge, snooze, drink detection
// (falling water level) and a low-water refill flag. Six active-low 7-segment
// digits show the remaining time.
module water_reminder_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LEVEL_W   = 4,
  parameter int LOW_LEVEL = 2,
  parameter int INT0      = 900,
  parameter int INT1      = 1800,
  parameter int INT2      = 2700,
  parameter int INT3      = 3600,
  parameter int SNOOZE_S  = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] water_level,
  input  logic [1:0]         selectLine,
  input  logic               ack,
  input  logic               snooze,
  output logic               remind,
  output logic               refill,
  output logic [6:0]         display0,
  output logic [6:0]         display1,
  output logic [6:0]         display2,
  output logic [6:0]         display3,
  output logic [6:0]         display4,
  output logic [6:0]         display5
);

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    ALERT  = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  // Largest value of each BCD digit, used as the wrap value on a borrow:
  // {h10, h1, m10, m1, s10, s1}.
  localparam logic [23:0] DIGIT_MAX = 24'h995959;
  localparam logic [23:0] BCD_ONE   = 24'h000001;
  localparam logic [23:0] BCD_ZERO  = 24'h000000;

  // Converts a whole number of seconds into packed BCD HHMMSS digits.
  function automatic logic [23:0] to_bcd(input int secs);
    int h;
    int m;
    int s;
    h = secs / 3600;
    m = (secs % 3600) / 60;
    s = secs % 60;
    to_bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10)};
  endfunction

  localparam logic [23:0] INT0_BCD   = to_bcd(INT0);
  localparam logic [23:0] INT1_BCD   = to_bcd(INT1);
  localparam logic [23:0] INT2_BCD   = to_bcd(INT2);
  localparam logic [23:0] INT3_BCD   = to_bcd(INT3);
  localparam logic [23:0] SNOOZE_BCD = to_bcd(SNOOZE_S);

  // Subtracts one second, rippling the borrow from seconds up to hours.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = DIGIT_MAX[i*4 +: 4];
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    bcd_dec = r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 falls back to a zero so
  // the display is never blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h40;
    endcase
  endfunction

  state_t             state;
  state_t             state_next;
  logic [23:0]        remaining;
  logic [23:0]        remaining_next;
  logic [23:0]        remaining_load;
  logic [23:0]        interval_bcd;
  logic [PRE_W-1:0]   prescaler;
  logic [PRE_W-1:0]   prescaler_next;
  logic [LEVEL_W-1:0] level_prev;
  logic [1:0]         sel_prev;
  logic               tick;
  logic               drink;
  logic               sel_changed;
  logic               reload;

  // Selects the reload interval for the currently selected line.
  always_comb begin
    interval_bcd = INT0_BCD;
    case (selectLine)
      2'd0: interval_bcd = INT0_BCD;
      2'd1: interval_bcd = INT1_BCD;
      2'd2: interval_bcd = INT2_BCD;
      2'd3: interval_bcd = INT3_BCD;
      default: interval_bcd = INT0_BCD;
    endcase
  end

  assign tick        = (prescaler == PRE_LAST);
  assign drink       = (water_level < level_prev);
  assign sel_changed = (selectLine != sel_prev);

  // Next-state logic in priority order: select change, ack, drink, snooze, tick.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    reload         = 1'b0;
    if (sel_changed) begin
      state_next     = COUNT;
      remaining_next = interval_bcd;
      reload         = 1'b1;
    end else if (state == ALERT) begin
      if (ack || drink) begin
        state_next     = COUNT;
        remaining_next = interval_bcd;
        reload         = 1'b1;
      end else if (snooze) begin
        state_next     = SNOOZE;
        remaining_next = SNOOZE_BCD;
        reload         = 1'b1;
      end
    end else begin
      if (drink) begin
        state_next     = COUNT;
        remaining_next = interval_bcd;
        reload         = 1'b1;
      end else if (tick) begin
        if ((remaining == BCD_ONE) || (remaining == BCD_ZERO)) begin
          state_next     = ALERT;
          remaining_next = BCD_ZERO;
        end else begin
          remaining_next = bcd_dec(remaining);
        end
      end
    end
  end

  // Any reload restarts the second so a full tick precedes the next decrement.
  always_comb begin
    prescaler_next = prescaler + PRE_W'(1);
    if (reload || tick) begin
      prescaler_next = '0;
    end
  end

  // Value the digit registers will hold after this edge, reset included.
  always_comb begin
    remaining_load = remaining_next;
    if (reset) begin
      remaining_load = interval_bcd;
    end
  end

  // State, countdown, prescaler and edge-detect history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COUNT;
      remaining  <= interval_bcd;
      prescaler  <= '0;
      level_prev <= water_level;
      sel_prev   <= selectLine;
      remind     <= 1'b0;
      refill     <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      prescaler  <= prescaler_next;
      level_prev <= water_level;
      sel_prev   <= selectLine;
      remind     <= (state_next == ALERT);
      refill     <= (water_level <= LEVEL_W'(LOW_LEVEL));
    end
  end

  // Registered segment outputs tracking the countdown digits.
  always_ff @(posedge clk) begin
    display0 <= seg7(remaining_load[3:0]);
    display1 <= seg7(remaining_load[7:4]);
    display2 <= seg7(remaining_load[11:8]);
    display3 <= seg7(remaining_load[15:12]);
    display4 <= seg7(remaining_load[19:16]);
    display5 <= seg7(remaining_load[23:20]);
  end

endmodule

// File: tb/tb_water_reminder_timer.sv
// Testbench for water_reminder_timer: directed scenarios followed by random
// stimulus, checked every cycle against a seconds-based behavioural model.
module tb_water_reminder_timer;

  localparam int CLK_HZ    = 4;
  localparam int LEVEL_W   = 4;
  localparam int LOW_LEVEL = 2;
  localparam int SNOOZE_S  = 3;

  logic               clk;
  logic               reset;
  logic [LEVEL_W-1:0] water_level;
  logic [1:0]         selectLine;
  logic               ack;
  logic               snooze;
  logic               remind;
  logic               refill;
  logic [6:0]         display0, display1, display2, display3, display4, display5;

  int errors = 0;
  int checks = 0;

  int intTab [4] = '{5, 65, 3600, 2};

  // Reference model: remaining time in plain seconds, mode 0=count 1=alert 2=snooze.
  int mMode, mRem, mPres, mLprev, mSprev;
  bit mRemind, mRefill;

  int curSel, curLvl;

  water_reminder_timer #(
    .CLK_HZ(CLK_HZ), .LEVEL_W(LEVEL_W), .LOW_LEVEL(LOW_LEVEL),
    .INT0(5), .INT1(65), .INT2(3600), .INT3(2), .SNOOZE_S(SNOOZE_S)
  ) dut (
    .clk(clk), .reset(reset), .water_level(water_level), .selectLine(selectLine),
    .ack(ack), .snooze(snooze), .remind(remind), .refill(refill),
    .display0(display0), .display1(display1), .display2(display2),
    .display3(display3), .display4(display4), .display5(display5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: segOf = 7'h40;  1: segOf = 7'h79;  2: segOf = 7'h24;  3: segOf = 7'h30;
      4: segOf = 7'h19;  5: segOf = 7'h12;  6: segOf = 7'h02;  7: segOf = 7'h78;
      8: segOf = 7'h00;  9: segOf = 7'h10;  default: segOf = 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] expDisplay(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs % 3600) / 60;
    s = secs % 60;
    expDisplay = {segOf(h / 10), segOf(h % 10), segOf(m / 10), segOf(m % 10),
                  segOf(s / 10), segOf(s % 10)};
  endfunction

  task automatic updateModel(input int sel, input int lvl, input bit a, input bit sn, input bit rst);
    bit drink, tick, reload;
    if (rst) begin
      mMode = 0; mRem = intTab[sel]; mPres = 0;
      mRemind = 0; mRefill = 0;
    end else begin
      drink  = (lvl < mLprev);
      tick   = (mPres == CLK_HZ - 1);
      reload = 0;
      if (sel != mSprev) begin
        mRem = intTab[sel]; mMode = 0; reload = 1;
      end else if (mMode == 1) begin
        if (a || drink) begin
          mRem = intTab[sel]; mMode = 0; reload = 1;
        end else if (sn) begin
          mRem = SNOOZE_S; mMode = 2; reload = 1;
        end
      end else if (drink) begin
        mRem = intTab[sel]; mMode = 0; reload = 1;
      end else if (tick) begin
        mRem = mRem - 1;
        if (mRem == 0) mMode = 1;
      end
      mPres   = (reload || tick) ? 0 : mPres + 1;
      mRemind = (mMode == 1);
      mRefill = (lvl <= LOW_LEVEL);
    end
    mLprev = lvl;
    mSprev = sel;
  endtask

  task automatic checkOutput(input string tag);
    logic [41:0] disp;
    disp = {display5, display4, display3, display2, display1, display0};
    checks++;
    assert (remind === mRemind) else begin
      errors++;
      $error("[TB] FAIL %s remind got=%0b exp=%0b", tag, remind, mRemind);
    end
    checks++;
    assert (refill === mRefill) else begin
      errors++;
      $error("[TB] FAIL %s refill got=%0b exp=%0b", tag, refill, mRefill);
    end
    checks++;
    assert (disp === expDisplay(mRem)) else begin
      errors++;
      $error("[TB] FAIL %s display got=%h exp=%h", tag, disp, expDisplay(mRem));
    end
  endtask

  task automatic checkConst(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model on the edge, then checks.
  task automatic applyStimulus(input int sel, input int lvl, input bit a, input bit sn,
                               input bit rst, input string tag);
    selectLine  = 2'(sel);
    water_level = LEVEL_W'(lvl);
    ack         = a;
    snooze      = sn;
    reset       = rst;
    @(posedge clk);
    updateModel(sel, lvl, a, sn, rst);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(curSel, curLvl, 0, 0, 0, tag);
  endtask

  initial begin
    curSel = 0; curLvl = 8;
    mLprev = 8; mSprev = 0;

    // 1. Reset and count down to the first alert.
    applyStimulus(curSel, curLvl, 0, 0, 1, "reset");
    applyStimulus(curSel, curLvl, 0, 0, 1, "reset");
    checkConst("rst_remind", 64'(remind), 64'd0);
    checkConst("rst_disp0", 64'(display0), 64'h12);
    checkConst("rst_disp1", 64'(display1), 64'h40);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(curSel, curLvl, 0, 0, 0, "count1");
      if (i == 4)  checkConst("t1_after_tick", 64'(display0), 64'h19);
      if (i == 19) checkConst("t1_remind_early", 64'(remind), 64'd0);
      if (i == 20) checkConst("t1_remind_on", 64'(remind), 64'd1);
    end
    checkConst("t1_disp_zero", 64'({display5, display4, display3, display2, display1, display0}),
               64'({6{7'h40}}));

    // 2. Acknowledge reloads and the alert recurs 20 cycles later.
    applyStimulus(curSel, curLvl, 1, 0, 0, "ack");
    checkConst("t2_remind_off", 64'(remind), 64'd0);
    checkConst("t2_disp0", 64'(display0), 64'h12);
    idle(20, "count2");
    checkConst("t2_remind_again", 64'(remind), 64'd1);

    // 3. Snooze for 3 s, then ack+snooze together favours ack.
    applyStimulus(curSel, curLvl, 0, 1, 0, "snooze");
    checkConst("t3_remind_off", 64'(remind), 64'd0);
    checkConst("t3_disp0", 64'(display0), 64'h30);
    idle(11, "snoozing");
    checkConst("t3_remind_early", 64'(remind), 64'd0);
    idle(1, "snoozing");
    checkConst("t3_remind_on", 64'(remind), 64'd1);
    applyStimulus(curSel, curLvl, 1, 1, 0, "ack_snooze");
    checkConst("t3_both_disp0", 64'(display0), 64'h12);
    idle(20, "count3");

    // 4. Borrow across minutes and hours.
    curSel = 1;
    applyStimulus(curSel, curLvl, 0, 0, 0, "sel1");
    checkConst("t4_105", 64'({display2, display1, display0}), 64'({7'h79, 7'h40, 7'h12}));
    idle(24, "count105");
    checkConst("t4_059", 64'({display2, display1, display0}), 64'({7'h40, 7'h12, 7'h10}));
    curSel = 2;
    applyStimulus(curSel, curLvl, 0, 0, 0, "sel2");
    checkConst("t4_010000", 64'({display5, display4, display3, display2, display1, display0}),
               64'({7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}));
    idle(4, "count3600");
    checkConst("t4_005959", 64'({display5, display4, display3, display2, display1, display0}),
               64'({7'h40, 7'h40, 7'h12, 7'h10, 7'h12, 7'h10}));

    // 5. Drink reloads, rising level does not, low level raises refill.
    curSel = 0;
    applyStimulus(curSel, curLvl, 0, 0, 0, "sel0");
    idle(6, "count5");
    checkConst("t5_pre_drink", 64'(display0), 64'h19);
    curLvl = 7;
    applyStimulus(curSel, curLvl, 0, 0, 0, "drink");
    checkConst("t5_drink_reload", 64'(display0), 64'h12);
    curLvl = 9;
    applyStimulus(curSel, curLvl, 0, 0, 0, "rise");
    checkConst("t5_rise_hold", 64'(display0), 64'h12);
    idle(3, "after_rise");
    checkConst("t5_rise_ticks", 64'(display0), 64'h19);
    checkConst("t5_refill_off", 64'(refill), 64'd0);
    curLvl = 2;
    applyStimulus(curSel, curLvl, 0, 0, 0, "low");
    checkConst("t5_refill_on", 64'(refill), 64'd1);

    // 6. Select change in ALERT, then reset during SNOOZE.
    idle(20, "count6");
    checkConst("t6_alert", 64'(remind), 64'd1);
    curSel = 3;
    applyStimulus(curSel, curLvl, 0, 0, 0, "sel3");
    checkConst("t6_sel_remind", 64'(remind), 64'd0);
    checkConst("t6_sel_disp0", 64'(display0), 64'h24);
    idle(8, "count2s");
    checkConst("t6_alert2", 64'(remind), 64'd1);
    applyStimulus(curSel, curLvl, 0, 1, 0, "snooze6");
    idle(2, "snoozing6");
    applyStimulus(curSel, curLvl, 0, 0, 1, "reset6");
    checkConst("t6_rst_remind", 64'(remind), 64'd0);
    checkConst("t6_rst_disp0", 64'(display0), 64'h24);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      bit a, sn, rst;
      if ($urandom_range(39) == 0) curSel = $urandom_range(3);
      if ($urandom_range(7) == 0)  curLvl = $urandom_range(15);
      a   = ($urandom_range(11) == 0);
      sn  = ($urandom_range(11) == 0);
      rst = ($urandom_range(249) == 0);
      applyStimulus(curSel, curLvl, a, sn, rst, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
